// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and op-decode helpers for the iterative RV32M multiply/divide
// unit (muldiv_unit) and its helpers.
//   muldiv_op_t    : 3-bit M-extension op encoding (funct3 order)
//   muldiv_state_t : control FSM states
//   OP_IS_DIV / OP_IS_REM / OP_IS_SIGNED_A / OP_IS_SIGNED_B : op decode
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    // DIV/DIVU/REM/REMU all have the top bit set.
    function automatic logic OP_IS_DIV(input logic [2:0] o);
        return o[2];
    endfunction

    // REM/REMU return the remainder half of the accumulator.
    function automatic logic OP_IS_REM(input logic [2:0] o);
        return o[2] & o[1];
    endfunction

    // rs1 is treated as two's complement for MULH, MULHSU, DIV, REM.
    function automatic logic OP_IS_SIGNED_A(input logic [2:0] o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV, REM.
    function automatic logic OP_IS_SIGNED_B(input logic [2:0] o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate. Used both to turn signed
// operands into magnitudes and to re-apply the result sign.
//   value  [WIDTH-1:0] in  : input word
//   negate             in  : 1 = output -value, 0 = pass through
//   result [WIDTH-1:0] out : corrected word
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Invert-and-increment, driven by the same select so no mux is needed.
    assign result = (value ^ {WIDTH{negate}}) + {{(WIDTH-1){1'b0}}, negate};

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit, one result bit per cycle. Multiply is
// shift-add, divide is restoring; both share one 2*WIDTH accumulator and the
// iteration counter. Divide-by-zero and signed overflow resolve in one cycle.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// DIV/DIVU/REM/REMU complete in one cycle with out=0, div_by_zero=0.
//
// Ports:
//   clk, rst_n (async, active-low), flush (sync abort)
//   in_valid / in_ready    : op handshake (in_ready high only in IDLE)
//   op [2:0], dataA, dataB : M-ext op and rs1/rs2 operands
//   out_valid / out_ready  : result handshake (result held until accepted)
//   out, zero, div_by_zero : registered result and flags
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             div_by_zero
);

    muldiv_state_t      state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;    // multiplicand or divisor magnitude
    logic [2:0]         op_reg, op_next;
    logic               neg_reg, neg_next;      // result must be negated
    logic [WIDTH-1:0]   out_reg, out_next;
    logic               zero_reg, zero_next;
    logic               dbz_reg, dbz_next;

    // ---------------- operand preparation ----------------
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign sign_a = OP_IS_SIGNED_A(op) & dataA[WIDTH-1];
    assign sign_b = OP_IS_SIGNED_B(op) & dataB[WIDTH-1];

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.value(dataA), .negate(sign_a), .result(mag_a));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.value(dataB), .negate(sign_b), .result(mag_b));

    // ---------------- one-cycle special cases ----------------
    logic             is_special;
    logic [WIDTH-1:0] special_out;
    logic             special_dbz;
    logic             neg_in;

`ifdef MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        is_special  = 1'b0;
        special_out = '0;
        special_dbz = 1'b0;
        if (OP_IS_DIV(op)) begin
            if (dataB == '0) begin
                is_special  = 1'b1;
                special_dbz = 1'b1;
                special_out = OP_IS_REM(op) ? dataA : '1;
            end else if (OP_IS_SIGNED_B(op) && (dataA == MOST_NEG) && (dataB == '1)) begin
                is_special  = 1'b1;
                special_out = OP_IS_REM(op) ? '0 : dataA;
            end
        end
    end

    // Remainder follows the dividend; quotient and product follow sign XOR.
    assign neg_in = OP_IS_REM(op) ? sign_a : (sign_a ^ sign_b);
`else
    assign is_special  = OP_IS_DIV(op);
    assign special_out = '0;
    assign special_dbz = 1'b0;
    assign neg_in      = sign_a ^ sign_b;
`endif

    // ---------------- iteration step ----------------
    // Multiply: acc = {partial product, remaining multiplier bits}. Add the
    // multiplicand into the top half when the low bit is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                                 : {1'b0, acc_reg[2*WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Divide: acc = {partial remainder, dividend/quotient}. Trial-subtract
    // the divisor from the shifted remainder (WIDTH+1 bits, so the borrow
    // shows up in the MSB) and shift in the quotient bit.
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;

    assign div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
    assign div_step = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    assign step     = OP_IS_DIV(op_reg) ? div_step : mul_step;
`else
    assign step     = mul_step;
`endif

    // ---------------- result sign correction ----------------
    // Negation is applied to the full 2*WIDTH product so MULH* high halves
    // pick up the borrow from the low half correctly.
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   result;

    always_comb begin
        fix_in = step;
`ifdef MULDIV_DIV_EN
        if (OP_IS_DIV(op_reg)) begin
            fix_in = OP_IS_REM(op_reg) ? {{WIDTH{1'b0}}, step[2*WIDTH-1:WIDTH]}
                                       : {{WIDTH{1'b0}}, step[WIDTH-1:0]};
        end
`endif
    end

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_res (.value(fix_in), .negate(neg_reg), .result(fix_out));

    assign result = ((op_reg == OP_MUL) || OP_IS_DIV(op_reg)) ? fix_out[WIDTH-1:0]
                                                               : fix_out[2*WIDTH-1:WIDTH];

    // ---------------- control ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        opnd_next  = opnd_reg;
        op_next    = op_reg;
        neg_next   = neg_reg;
        out_next   = out_reg;
        zero_next  = zero_reg;
        dbz_next   = dbz_reg;

        if (flush) begin
            // Abort wins over everything, including a same-cycle handshake.
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_next  = op;
                        neg_next = neg_in;
                        if (OP_IS_DIV(op)) begin
                            acc_next  = {{WIDTH{1'b0}}, mag_a};
                            opnd_next = mag_b;
                        end else begin
                            acc_next  = {{WIDTH{1'b0}}, mag_b};
                            opnd_next = mag_a;
                        end
                        if (is_special) begin
                            state_next = ST_DONE;
                            cnt_next   = '0;
                            out_next   = special_out;
                            zero_next  = (special_out == '0);
                            dbz_next   = special_dbz;
                        end else begin
                            state_next = ST_BUSY;
                            cnt_next   = CNT_W'(WIDTH);
                        end
                    end
                end
                ST_BUSY: begin
                    acc_next = step;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_DONE;
                        out_next   = result;
                        zero_next  = (result == '0);
                        dbz_next   = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            op_reg    <= '0;
            neg_reg   <= 1'b0;
            out_reg   <= '0;
            zero_reg  <= 1'b1;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            opnd_reg  <= opnd_next;
            op_reg    <= op_next;
            neg_reg   <= neg_next;
            out_reg   <= out_next;
            zero_reg  <= zero_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign out_valid   = (state_reg == ST_DONE);
    assign out         = out_reg;
    assign zero        = zero_reg;
    assign div_by_zero = dbz_reg;

endmodule
